// File: rtl/uart_proto_pkg.sv
// Shared constants, state encodings and framing helper for the UART register protocol.
// Frame: {write, addr[6:0]} then 4 little-endian data bytes for writes.
package uart_proto_pkg;

   localparam int FRAME_BYTES    = 4;
   localparam int WRITE_FLAG_BIT = 7;
   localparam int CLK_HZ         = 50_000_000;
   localparam int BAUD           = 115_200;
   localparam int CLKS_PER_BIT   = CLK_HZ / BAUD;

   typedef enum logic [1:0] {
      M_IDLE,
      M_TX,
      M_RX_COLLECT,
      M_DONE
   } mst_state_e;

   typedef enum logic [1:0] {
      Q_IDLE,
      Q_TX_LAUNCH,
      Q_TX_WAIT_HI,
      Q_TX_WAIT_LO
   } seq_state_e;

   // Byte idx of the outgoing frame: 0 = address byte, 1..4 = data lanes.
   function automatic logic [7:0] frame_byte(
      input logic        wr,
      input logic [6:0]  addr,
      input logic [31:0] wdata,
      input logic [2:0]  idx
   );
      logic [7:0] b;
      case (idx)
         3'd1: b = wdata[7:0];
         3'd2: b = wdata[15:8];
         3'd3: b = wdata[23:16];
         3'd4: b = wdata[31:24];
         default: begin
            b = {1'b0, addr};
            b[WRITE_FLAG_BIT] = wr;
         end
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_byte_sequencer.sv
// Launches n bytes through a busy-handshaked UART transmitter, one at a time.
// Each launch waits for busy to rise and then fall before the next byte.
module uart_byte_sequencer
   import uart_proto_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [2:0] n_bytes_i,
   input  logic [7:0] byte_i,
   input  logic       tx_busy_i,
   output logic [2:0] cnt_o,
   output logic       done_o,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o
);

   seq_state_e state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d;

   assign cnt_o      = cnt_q;
   assign tx_data_o  = tx_data_q;
   assign tx_valid_o = tx_valid_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         Q_IDLE: begin
            if (start_i) begin
               cnt_d   = '0;
               state_d = Q_TX_LAUNCH;
            end
         end
         Q_TX_LAUNCH: begin
            if (!tx_busy_i) begin
               tx_valid_d = 1'b1;
               tx_data_d  = byte_i;
               state_d    = Q_TX_WAIT_HI;
            end
         end
         // Busy must be seen high first so a slow transmitter is not relaunched.
         Q_TX_WAIT_HI: begin
            if (tx_busy_i) state_d = Q_TX_WAIT_LO;
         end
         Q_TX_WAIT_LO: begin
            if (!tx_busy_i) begin
               if (cnt_q + 3'd1 == n_bytes_i) begin
                  done_o  = 1'b1;
                  cnt_d   = '0;
                  state_d = Q_IDLE;
               end else begin
                  cnt_d   = cnt_q + 3'd1;
                  state_d = Q_TX_LAUNCH;
               end
            end
         end
         default: state_d = Q_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= Q_IDLE;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

endmodule

// File: rtl/uart_bus_master.sv
// Host-side initiator: parallel register request -> UART frame, collects read replies.
// Define UART_MASTER_TIMEOUT_EN to enable the read-reply timeout and rsp_err.
module uart_bus_master
   import uart_proto_pkg::*;
#(
   parameter int D_WIDTH        = 32,
   parameter int A_WIDTH        = 7,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input  logic               clk50MHz,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [A_WIDTH-1:0] req_addr,
   input  logic [D_WIDTH-1:0] req_wdata,
   output logic               rsp_valid,
   output logic [D_WIDTH-1:0] rsp_rdata,
   output logic               rsp_err,
   output logic [7:0]         uart_tx_data,
   output logic               uart_tx_valid,
   input  logic               uart_tx_busy,
   input  logic [7:0]         uart_rx_data,
   input  logic               uart_rx_valid
);

   mst_state_e state_q, state_d;
   logic               wr_q;
   logic [A_WIDTH-1:0] addr_q;
   logic [D_WIDTH-1:0] wdata_q;
   logic [D_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]         lane_q, lane_d;
   logic               accept;
   logic               seq_done;
   logic               tmo_hit;
   logic [2:0]         seq_cnt;
   logic [2:0]         n_bytes;
   logic [7:0]         cur_byte;

   assign req_ready = (state_q == M_IDLE);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state_q == M_DONE);
   assign rsp_rdata = rdata_q;
   assign n_bytes   = wr_q ? 3'(FRAME_BYTES + 1) : 3'd1;
   assign cur_byte  = frame_byte(wr_q, addr_q, wdata_q, seq_cnt);

   uart_byte_sequencer u_seq (
      .clk_i      (clk50MHz),
      .rst_i      (rst),
      .start_i    (accept),
      .n_bytes_i  (n_bytes),
      .byte_i     (cur_byte),
      .tx_busy_i  (uart_tx_busy),
      .cnt_o      (seq_cnt),
      .done_o     (seq_done),
      .tx_data_o  (uart_tx_data),
      .tx_valid_o (uart_tx_valid)
   );

`ifdef UART_MASTER_TIMEOUT_EN
   localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
   logic [19:0] tmo_q, tmo_d;
   logic        err_q, err_d;

   assign tmo_hit = (tmo_q == TMO_LAST);
   assign rsp_err = err_q;

   // Counter runs only while collecting; any received byte restarts it.
   always_comb begin
      tmo_d = '0;
      err_d = err_q;
      if (accept) err_d = 1'b0;
      if (state_q == M_RX_COLLECT) begin
         if (uart_rx_valid) tmo_d = '0;
         else if (tmo_hit) err_d = 1'b1;
         else tmo_d = tmo_q + 20'd1;
      end
   end

   always_ff @(posedge clk50MHz or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      lane_d  = lane_q;
      case (state_q)
         M_IDLE: begin
            if (accept) begin
               rdata_d = '0;
               lane_d  = '0;
               state_d = M_TX;
            end
         end
         M_TX: begin
            if (seq_done) state_d = wr_q ? M_DONE : M_RX_COLLECT;
         end
         M_RX_COLLECT: begin
            if (uart_rx_valid) begin
               rdata_d[8*lane_q +: 8] = uart_rx_data;
               lane_d = lane_q + 2'd1;
               if (lane_q == 2'(FRAME_BYTES - 1)) state_d = M_DONE;
            end else if (tmo_hit) begin
               state_d = M_DONE;
            end
         end
         M_DONE: begin
            lane_d  = '0;
            state_d = M_IDLE;
         end
         default: state_d = M_IDLE;
      endcase
   end

   always_ff @(posedge clk50MHz or posedge rst) begin
      if (rst) begin
         state_q <= M_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         lane_q  <= lane_d;
         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a frame/reply model and per-cycle compare.
// Define UART_MASTER_TIMEOUT_EN to also run the reply-timeout case.
module tb_uart_bus_master;

`ifdef UART_MASTER_TIMEOUT_EN
   localparam int TMO = 1000;
`else
   localparam int TMO = 500000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [6:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_busy;
   logic [7:0]  uart_rx_data = '0;
   logic        uart_rx_valid = 1'b0;
   logic        mbusy = 1'b0;
   logic        force_busy = 1'b0;

   assign uart_tx_busy = mbusy | force_busy;

   always #10 clk = ~clk;

   uart_bus_master #(
      .D_WIDTH(32), .A_WIDTH(7), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk50MHz      (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_busy  (uart_tx_busy),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid)
   );

   typedef struct {
      bit          wr;
      logic [31:0] rdata;
      bit          err;
   } rsp_t;

   logic [7:0] exp_tx[$];
   logic [7:0] tx_log[$];
   rsp_t       exp_rsp[$];
   logic [7:0] reply_b [4];
   logic [7:0] lit [5] = '{8'h85, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
   int reply_n = 4;
   int checks = 0, failures = 0;
   int strobes = 0, pulses = 0, tx_done = 0;
   int since_fall = 0, since_rx = 0;
   bit outst = 0, prev_busy = 0;
   int rise_dly = 0, busy_len = 10;
   int ph = 0, dly = 0, bcnt = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s t=%0t", name, $time);
   endtask

   // Transmitter model: busy rises rise_dly cycles after a strobe, lasts busy_len.
   always @(posedge clk) begin
      if (rst) begin
         mbusy <= 1'b0;
         ph    <= 0;
      end else if (uart_tx_valid) begin
         if (rise_dly == 0) begin
            mbusy <= 1'b1;
            bcnt  <= busy_len;
            ph    <= 2;
         end else begin
            dly <= rise_dly;
            ph  <= 1;
         end
      end else if (ph == 1) begin
         if (dly == 1) begin
            mbusy <= 1'b1;
            bcnt  <= busy_len;
            ph    <= 2;
         end else dly <= dly - 1;
      end else if (ph == 2) begin
         if (bcnt == 1) begin
            mbusy   <= 1'b0;
            ph      <= 0;
            tx_done <= tx_done + 1;
         end else bcnt <= bcnt - 1;
      end
   end

   // Per-cycle compare against the frame/reply model.
   initial forever begin
      rsp_t e;
      @(negedge clk);
      if (rst) begin
         exp_tx.delete();
         exp_rsp.delete();
         outst     = 0;
         prev_busy = 0;
      end else begin
         since_fall++;
         since_rx++;
         chk("req_ready", {31'b0, req_ready}, {31'b0, !outst});
         if (uart_tx_valid) begin
            strobes++;
            tx_log.push_back(uart_tx_data);
            chk("busy_at_strobe", {31'b0, uart_tx_busy}, 0);
            if (exp_tx.size() == 0) fail("unexpected_tx");
            else chk("tx_byte", {24'b0, uart_tx_data}, {24'b0, exp_tx.pop_front()});
         end
         if (rsp_valid) begin
            pulses++;
            if (exp_rsp.size() == 0) fail("unexpected_rsp");
            else begin
               e = exp_rsp.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
               chk("tx_remaining", exp_tx.size(), 0);
               if (e.err) chk("tmo_latency_ok", {31'b0, since_rx <= TMO + 2}, 1);
               else if (e.wr) chk("wr_latency", since_fall, 1);
               else chk("rd_latency", since_rx, 1);
            end
            outst = 0;
         end
         if (prev_busy && !uart_tx_busy) since_fall = 0;
         if (uart_rx_valid) since_rx = 0;
         if (req_valid && !outst) begin
            outst = 1;
            e.wr = req_write;
            e.rdata = '0;
            e.err = 1'b0;
            exp_tx.push_back({req_write, req_addr});
            if (req_write) begin
               for (int i = 0; i < 4; i++) exp_tx.push_back(req_wdata[8*i +: 8]);
            end else begin
               for (int i = 0; i < reply_n; i++) e.rdata[8*i +: 8] = reply_b[i];
               e.err = (reply_n < 4);
            end
            exp_rsp.push_back(e);
         end
         prev_busy = uart_tx_busy;
      end
   end

   task automatic issue(input bit wr, input logic [6:0] a, input logic [31:0] d);
      bit ok = 0;
      @(posedge clk);
      #1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = ~wr;
      req_addr  = 7'h7F;
      req_wdata = 32'hFFFF_FFFF;
      if (!ok) fail("req_accept_timeout");
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(posedge clk);
      #1;
      uart_rx_data  = b;
      uart_rx_valid = 1'b1;
      @(posedge clk);
      #1;
      uart_rx_valid = 1'b0;
      uart_rx_data  = '0;
   endtask

   task automatic wait_txdone(input int target);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (tx_done >= target) return;
      end
      fail("txdone_timeout");
   endtask

   task automatic wait_rsp(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (rsp_valid) return;
      end
      fail("rsp_timeout");
   endtask

   task automatic send_reply();
      for (int i = 0; i < reply_n; i++) begin
         if (i > 0) repeat (4) @(posedge clk);
         send_rx(reply_b[i]);
      end
   endtask

   task automatic chk_reset();
      chk("rst_req_ready", {31'b0, req_ready}, 1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 0);
      chk("rst_tx_valid", {31'b0, uart_tx_valid}, 0);
      chk("rst_tx_data", {24'b0, uart_tx_data}, 0);
   endtask

   initial begin
      int s0, t0, p0, n;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // Write 0x05 <- 0xDEADBEEF
      s0 = strobes;
      p0 = pulses;
      issue(1'b1, 7'h05, 32'hDEAD_BEEF);
      wait_rsp(2000);
      chk("wr1_rdata", rsp_rdata, 0);
      chk("wr1_err", {31'b0, rsp_err}, 0);
      @(negedge clk);
      chk("wr1_strobes", strobes - s0, 5);
      chk("wr1_pulses", pulses - p0, 1);
      n = tx_log.size();
      if (n < 5) fail("wr1_txlog_short");
      else for (int i = 0; i < 5; i++)
         chk("wr1_tx_literal", {24'b0, tx_log[n-5+i]}, {24'b0, lit[i]});

      // Read 0x12, reply 78 56 34 12
      reply_b = '{8'h78, 8'h56, 8'h34, 8'h12};
      reply_n = 4;
      s0 = strobes;
      t0 = tx_done;
      issue(1'b0, 7'h12, 32'hCAFE_F00D);
      wait_txdone(t0 + 1);
      repeat (3) @(posedge clk);
      send_reply();
      wait_rsp(200);
      chk("rd1_rdata", rsp_rdata, 32'h1234_5678);
      @(negedge clk);
      chk("rd1_ready_after", {31'b0, req_ready}, 1);
      chk("rd1_rdata_held", rsp_rdata, 32'h1234_5678);
      chk("rd1_strobes", strobes - s0, 1);
      chk("rd1_addr_byte", {24'b0, tx_log[tx_log.size()-1]}, 32'h12);

      // Busy held 100 cycles, busy rises 3 cycles after each strobe
      rise_dly = 3;
      force_busy = 1'b1;
      s0 = strobes;
      issue(1'b1, 7'h7F, 32'h0102_0304);
      repeat (100) @(posedge clk);
      chk("hold_no_strobe", strobes - s0, 0);
      #1 force_busy = 1'b0;
      wait_rsp(3000);
      chk("wr2_rdata_cleared", rsp_rdata, 0);
      @(negedge clk);
      chk("wr2_strobes", strobes - s0, 5);
      rise_dly = 0;

      // Stray rx bytes in idle and during the address send
      send_rx(8'hAA);
      repeat (2) @(posedge clk);
      reply_b = '{8'h44, 8'h33, 8'h22, 8'h11};
      s0 = strobes;
      t0 = tx_done;
      issue(1'b0, 7'h33, 32'h0);
      for (int i = 0; i < 100 && strobes == s0; i++) @(negedge clk);
      send_rx(8'hAA);
      wait_txdone(t0 + 1);
      repeat (3) @(posedge clk);
      send_reply();
      wait_rsp(200);
      chk("rd2_rdata", rsp_rdata, 32'h1122_3344);

      // Reset after the 2nd reply byte
      t0 = tx_done;
      reply_b = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
      issue(1'b0, 7'h21, 32'h0);
      wait_txdone(t0 + 1);
      repeat (3) @(posedge clk);
      send_rx(8'h9A);
      repeat (3) @(posedge clk);
      send_rx(8'hBC);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk_reset();
      p0 = pulses;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      chk("no_rsp_after_reset", pulses - p0, 0);
      s0 = strobes;
      issue(1'b1, 7'h0A, 32'h55AA_00FF);
      wait_rsp(2000);
      chk("wr3_rdata", rsp_rdata, 0);
      @(negedge clk);
      chk("wr3_strobes", strobes - s0, 5);

`ifdef UART_MASTER_TIMEOUT_EN
      // Only two reply bytes: expect timeout with partial data
      reply_b = '{8'h11, 8'h22, 8'h00, 8'h00};
      reply_n = 2;
      t0 = tx_done;
      issue(1'b0, 7'h44, 32'h0);
      wait_txdone(t0 + 1);
      repeat (3) @(posedge clk);
      send_reply();
      wait_rsp(TMO + 50);
      chk("tmo_err", {31'b0, rsp_err}, 1);
      chk("tmo_rdata", rsp_rdata, 32'h0000_2211);
      @(negedge clk);
      reply_n = 4;
`endif

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      fail("watchdog");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
